// File: rtl/park_pkg.sv
// Shared types and constants for the parking-slot manager and its display consumers.
package park_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SHOW   = 2'd2
    } park_state_t;

    // Seven-segment glyphs (gfedcba) for zone letters and the blank/null glyph.
    localparam logic [6:0] SEG_ZONE_A = 7'h77;
    localparam logic [6:0] SEG_ZONE_B = 7'h7C;
    localparam logic [6:0] SEG_ZONE_C = 7'h39;
    localparam logic [6:0] SEG_ZONE_D = 7'h5E;
    localparam logic [6:0] SEG_NULL   = 7'h40;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/park_slot_manager_if.sv
// Request/leave/clean/readback bundle between the decoder, the slot manager and its consumers.
interface park_slot_manager_if #(
    parameter int ZONES = 2,
    parameter int SLOTS = 3,
    parameter int CNT_W = 9
);
    import park_pkg::*;
    localparam int ZW = clog2_min1(ZONES);
    localparam int SW = clog2_min1(SLOTS);

    logic                      park_req;
    logic [ZW-1:0]             park_zone;
    logic                      leave_req;
    logic [ZW-1:0]             leave_zone;
    logic [SW-1:0]             leave_slot;
    logic [ZONES-1:0]          clean;
    logic [ZONES*SLOTS-1:0]    slot_en;
    logic [CNT_W-1:0]          now;
    logic [ZW-1:0]             rd_zone;
    logic [SW-1:0]             rd_slot;
    logic [CNT_W-1:0]          rd_time;
    logic [ZONES*SLOTS-1:0]    occ;
    logic [ZONES*(SW+1)-1:0]   free_cnt;
    logic [1:0]                state;
    logic                      park_ack;
    logic                      park_fail;
    logic [ZW-1:0]             res_zone;
    logic [SW-1:0]             res_slot;

    modport master (
        output park_req, park_zone, leave_req, leave_zone, leave_slot,
               clean, slot_en, now, rd_zone, rd_slot,
        input  rd_time, occ, free_cnt, state, park_ack, park_fail, res_zone, res_slot
    );

    modport slave (
        input  park_req, park_zone, leave_req, leave_zone, leave_slot,
               clean, slot_en, now, rd_zone, rd_slot,
        output rd_time, occ, free_cnt, state, park_ack, park_fail, res_zone, res_slot
    );

endinterface

// File: rtl/park_prio_enc.sv
// Lowest-set-bit encoder used to pick the first open slot in a zone.
module park_prio_enc
    import park_pkg::*;
#(
    parameter int SLOTS = 3,
    localparam int SW = clog2_min1(SLOTS)
) (
    input  logic [SLOTS-1:0] req,
    output logic             found,
    output logic [SW-1:0]    idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = SW'(i);
            end
        end
    end

endmodule

// File: rtl/park_slot_manager.sv
// Parking-slot allocator: occupancy bitmap, per-zone free counts, entry timestamps.
//  state     | meaning
//  ST_IDLE   | waiting for park_req; latches the requested zone
//  ST_LOOKUP | one cycle: pick lowest open slot, grant or fail
//  ST_SHOW   | hold result for HOLD_CYC cycles (down-counter to zero)
module park_slot_manager
    import park_pkg::*;
#(
    parameter int ZONES    = 2,
    parameter int SLOTS    = 3,
    parameter int CNT_W    = 9,
    parameter int HOLD_CYC = 4
) (
    input logic             clk,
    input logic             rst,
    park_slot_manager_if.slave bus
);

    localparam int ZW = clog2_min1(ZONES);
    localparam int SW = clog2_min1(SLOTS);
    localparam int HW = clog2_min1(HOLD_CYC);
    localparam int NS = ZONES * SLOTS;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    park_state_t state_q, state_n;
    logic [HW-1:0]           hold_q, hold_n;
    logic [ZW-1:0]           zone_q;
    logic [NS-1:0]           occ_q, occ_n;
    logic [CNT_W-1:0]        stamp_q [NS];
    logic [CNT_W-1:0]        rd_time_q, rd_sel;
    logic [ZONES*(SW+1)-1:0] free_q, free_n;
    logic                    ack_q, fail_q;
    logic [ZW-1:0]           res_zone_q;
    logic [SW-1:0]           res_slot_q;

    logic                    zone_ok, clean_sel, found, grant, in_lookup;
    logic [SLOTS-1:0]        avail;
    logic [SW-1:0]           pick;
    logic [NS-1:0]           grant_vec, leave_vec, clean_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
        end
    end

    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        case (state_q)
            ST_IDLE:   if (bus.park_req) state_n = ST_LOOKUP;
            ST_LOOKUP: begin
                state_n = ST_SHOW;
                hold_n  = HOLD_LOAD;
            end
            ST_SHOW: begin
                if (hold_q == '0) state_n = ST_IDLE;
                else              hold_n  = hold_q - 1'b1;
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    assign in_lookup = (state_q == ST_LOOKUP);

    // An out-of-range latched zone matches no decode entry, so zone_ok stays low.
    always_comb begin
        zone_ok   = 1'b0;
        clean_sel = 1'b0;
        avail     = '0;
        for (int z = 0; z < ZONES; z++) begin
            if (zone_q == ZW'(z)) begin
                zone_ok   = 1'b1;
                clean_sel = bus.clean[z];
                avail     = bus.slot_en[z*SLOTS +: SLOTS] & ~occ_q[z*SLOTS +: SLOTS];
            end
        end
    end

    park_prio_enc #(.SLOTS(SLOTS)) u_prio (
        .req   (avail),
        .found (found),
        .idx   (pick)
    );

    assign grant = in_lookup && zone_ok && found && !clean_sel;

    always_comb begin
        grant_vec = '0;
        leave_vec = '0;
        clean_vec = '0;
        for (int z = 0; z < ZONES; z++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (grant && zone_q == ZW'(z) && pick == SW'(s))
                    grant_vec[z*SLOTS+s] = 1'b1;
                if (bus.leave_req && bus.leave_zone == ZW'(z) && bus.leave_slot == SW'(s))
                    leave_vec[z*SLOTS+s] = 1'b1;
                clean_vec[z*SLOTS+s] = bus.clean[z];
            end
        end
    end

    // Leave on an empty slot is a no-op since clearing a 0 bit changes nothing.
    assign occ_n = ((occ_q & ~leave_vec) | grant_vec) & ~clean_vec;

    always_comb begin
        rd_sel = '0;
        free_n = '0;
        for (int z = 0; z < ZONES; z++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (bus.rd_zone == ZW'(z) && bus.rd_slot == SW'(s))
                    rd_sel = stamp_q[z*SLOTS+s];
                free_n[z*(SW+1) +: SW+1] = free_n[z*(SW+1) +: SW+1]
                    + (SW+1)'(bus.slot_en[z*SLOTS+s] & ~occ_q[z*SLOTS+s]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q     <= '0;
            occ_q      <= '0;
            rd_time_q  <= '0;
            free_q     <= '0;
            ack_q      <= 1'b0;
            fail_q     <= 1'b0;
            res_zone_q <= '0;
            res_slot_q <= '0;
            for (int i = 0; i < NS; i++) stamp_q[i] <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.park_req) zone_q <= bus.park_zone;
            occ_q     <= occ_n;
            rd_time_q <= rd_sel;
            free_q    <= free_n;
            ack_q     <= grant;
            fail_q    <= in_lookup && !grant;
            if (in_lookup) begin
                res_zone_q <= zone_q;
                res_slot_q <= grant ? pick : '0;
            end
            for (int i = 0; i < NS; i++) begin
                if (grant_vec[i])                     stamp_q[i] <= bus.now;
                else if (leave_vec[i] || clean_vec[i]) stamp_q[i] <= '0;
            end
        end
    end

    assign bus.rd_time   = rd_time_q;
    assign bus.occ       = occ_q;
    assign bus.free_cnt  = free_q;
    assign bus.state     = state_q;
    assign bus.park_ack  = ack_q;
    assign bus.park_fail = fail_q;
    assign bus.res_zone  = res_zone_q;
    assign bus.res_slot  = res_slot_q;

endmodule

// File: tb/tb_park_slot_manager.sv
// Directed bench for park_slot_manager (2 zones x 3 slots, hold 4 cycles).
module tb_park_slot_manager;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    park_slot_manager_if #(.ZONES(2), .SLOTS(3), .CNT_W(9)) bus ();

    park_slot_manager #(.ZONES(2), .SLOTS(3), .CNT_W(9), .HOLD_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic park_begin(input int zone, input int now_val);
        bus.now       = 9'(now_val);
        bus.park_zone = 1'(zone);
        bus.park_req  = 1'b1;
        step();
        bus.park_req  = 1'b0;
        check("state_lookup", 32'(bus.state), 1);
    endtask

    task automatic park_end(input string tag, input logic exp_ack, input int exp_slot);
        step();
        bus.leave_req = 1'b0;
        bus.clean     = '0;
        check({tag, "_ack"},  32'(bus.park_ack),  32'(exp_ack));
        check({tag, "_fail"}, 32'(bus.park_fail), 32'(!exp_ack));
        check({tag, "_slot"}, 32'(bus.res_slot),  32'(exp_slot));
        check({tag, "_show"}, 32'(bus.state),     2);
        step();
        check({tag, "_pulse"}, 32'(bus.park_ack | bus.park_fail), 0);
        step();
        step();
        check({tag, "_hold"}, 32'(bus.state), 2);
        step();
        check({tag, "_idle"}, 32'(bus.state), 0);
    endtask

    task automatic read_stamp(input string tag, input int z, input int s, input int exp);
        bus.rd_zone = 1'(z);
        bus.rd_slot = 2'(s);
        step();
        check(tag, 32'(bus.rd_time), 32'(exp));
    endtask

    task automatic leave(input int z, input int s);
        bus.leave_zone = 1'(z);
        bus.leave_slot = 2'(s);
        bus.leave_req  = 1'b1;
        step();
        bus.leave_req  = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.park_req   = 1'b0;
        bus.park_zone  = '0;
        bus.leave_req  = 1'b0;
        bus.leave_zone = '0;
        bus.leave_slot = '0;
        bus.clean      = '0;
        bus.slot_en    = 6'b111111;
        bus.now        = '0;
        bus.rd_zone    = '0;
        bus.rd_slot    = '0;
        step();
        step();
        check("rst_free", 32'(bus.free_cnt), 0);
        check("rst_occ",  32'(bus.occ),      0);
        check("rst_state", 32'(bus.state),   0);
        rst = 1'b0;
        step();
        check("init_free", 32'(bus.free_cnt), 6'b011_011);
        check("init_occ",  32'(bus.occ),      0);

        // Fill zone 0, then one more request must fail.
        park_begin(0, 5); park_end("p0", 1'b1, 0);
        park_begin(0, 6); park_end("p1", 1'b1, 1);
        park_begin(0, 7); park_end("p2", 1'b1, 2);
        check("full_occ",  32'(bus.occ),      6'b000_111);
        check("full_free", 32'(bus.free_cnt), 6'b011_000);
        read_stamp("stamp_z0s0", 0, 0, 5);
        read_stamp("stamp_z0s1", 0, 1, 6);
        read_stamp("stamp_z0s2", 0, 2, 7);
        park_begin(0, 8); park_end("p3", 1'b0, 0);
        check("fail_occ", 32'(bus.occ), 6'b000_111);

        // Leave frees slot 1, which is re-granted; leaves on empty/out-of-range are ignored.
        leave(0, 1);
        check("leave_occ", 32'(bus.occ), 6'b000_101);
        step();
        check("leave_free", 32'(bus.free_cnt), 6'b011_001);
        read_stamp("leave_stamp", 0, 1, 0);
        park_begin(0, 9); park_end("p4", 1'b1, 1);
        leave(1, 0);
        leave(0, 3);
        step();
        check("empty_leave_occ",  32'(bus.occ),      6'b000_111);
        check("empty_leave_free", 32'(bus.free_cnt), 6'b011_000);

        // Grant z1/s0 in the same cycle as a leave of z1/s2.
        park_begin(1, 10); park_end("p5", 1'b1, 0);
        park_begin(1, 11); park_end("p6", 1'b1, 1);
        park_begin(1, 12); park_end("p7", 1'b1, 2);
        leave(1, 0);
        step();
        check("pre_both_occ",  32'(bus.occ),      6'b110_111);
        check("pre_both_free", 32'(bus.free_cnt), 6'b001_000);
        park_begin(1, 13);
        bus.leave_zone = 1'b1;
        bus.leave_slot = 2'd2;
        bus.leave_req  = 1'b1;
        step();
        bus.leave_req  = 1'b0;
        check("both_ack",  32'(bus.park_ack), 1);
        check("both_slot", 32'(bus.res_slot), 0);
        check("both_occ",  32'(bus.occ),      6'b011_111);
        step();
        check("both_free", 32'(bus.free_cnt), 6'b001_000);
        step(); step(); step();
        check("both_idle", 32'(bus.state), 0);
        read_stamp("both_stamp_s0", 1, 0, 13);
        read_stamp("both_stamp_s2", 1, 2, 0);

        // Clean zone 0 while a zone-0 lookup would otherwise grant slot 0.
        leave(0, 0);
        check("pre_clean_occ", 32'(bus.occ), 6'b011_110);
        park_begin(0, 14);
        bus.clean = 2'b01;
        park_end("pclean", 1'b0, 0);
        check("clean_occ",  32'(bus.occ),      6'b011_000);
        check("clean_free", 32'(bus.free_cnt), 6'b001_011);
        read_stamp("clean_z0s1", 0, 1, 0);
        read_stamp("clean_z0s2", 0, 2, 0);
        read_stamp("clean_keep_z1s1", 1, 1, 11);

        // Disabled slot 0 is skipped; reset during SHOW aborts.
        bus.slot_en = 6'b111_110;
        park_begin(0, 20); park_end("pen", 1'b1, 1);
        check("en_occ",  32'(bus.occ),      6'b011_010);
        check("en_free", 32'(bus.free_cnt), 6'b001_001);
        read_stamp("en_stamp", 0, 1, 20);
        park_begin(0, 21);
        step();
        check("rst_show_ack", 32'(bus.park_ack), 1);
        step();
        rst = 1'b1;
        step();
        check("rst_show_state", 32'(bus.state),     0);
        check("rst_show_occ",   32'(bus.occ),       0);
        check("rst_show_ack0",  32'(bus.park_ack),  0);
        check("rst_show_fail0", 32'(bus.park_fail), 0);
        rst = 1'b0;
        step();
        step();
        check("rst_show_idle", 32'(bus.state), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
